// File: rtl/sser_window_ctrl.sv
// Arbiter and access sequencer for the serial-port register window: shares the
// window between CPU and DMA, drives BA/BR_W/SSER timing and returns SDRD.
module sser_window_ctrl #(
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_req,
   input  logic       cpu_rw,
   input  logic [3:0] cpu_addr,
   input  logic       cpu_lock,
   output logic       cpu_gnt,
   output logic       cpu_done,
   output logic       cpu_rdata,
   input  logic       dma_req,
   input  logic       dma_rw,
   input  logic [3:0] dma_addr,
   input  logic       dma_lock,
   output logic       dma_gnt,
   output logic       dma_done,
   output logic       dma_rdata,
   output logic [3:0] ba,
   output logic       ba12,
   output logic       ba13,
   output logic       br_w,
   output logic       sser_n,
   input  logic       sdrd
);

   if (STROBE_CYC == 0 || STROBE_CYC > 15 || HOLD_CYC == 0 || HOLD_CYC > 15) begin : g_bad_cfg
      $error("sser_window_ctrl: STROBE_CYC and HOLD_CYC must be in 1..15");
   end

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

   state_e     state_q;
   owner_e     owner_q;
   logic [3:0] cnt_q;
   logic       last_dma_q;
   logic       win_dma_q;
   logic       lock_q;
   logic [3:0] ba_q;
   logic       ba12_q, ba13_q, br_w_q, sser_n_q;
   logic       cpu_gnt_q, cpu_done_q, cpu_rdata_q;
   logic       dma_gnt_q, dma_done_q, dma_rdata_q;

   logic       win_valid_d;
   logic       win_dma_d;

   // A lock owner shuts the other requester out; otherwise round-robin on ties.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      win_valid_d = 1'b0;
      win_dma_d   = 1'b0;
      case (owner_q)
         OWN_CPU: win_valid_d = cpu_req;
         OWN_DMA: begin
            win_valid_d = dma_req;
            win_dma_d   = 1'b1;
         end
         default: begin
            win_valid_d = cpu_req | dma_req;
            win_dma_d   = dma_req & (~cpu_req | ~last_dma_q);
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         cnt_q       <= '0;
         last_dma_q  <= 1'b1;
         win_dma_q   <= 1'b0;
         lock_q      <= 1'b0;
         ba_q        <= '0;
         ba12_q      <= 1'b0;
         ba13_q      <= 1'b1;
         br_w_q      <= 1'b1;
         sser_n_q    <= 1'b1;
         cpu_gnt_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         cpu_rdata_q <= 1'b0;
         dma_gnt_q   <= 1'b0;
         dma_done_q  <= 1'b0;
         dma_rdata_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_valid_d) begin
                  state_q    <= S_SETUP;
                  win_dma_q  <= win_dma_d;
                  last_dma_q <= win_dma_d;
                  lock_q     <= win_dma_d ? dma_lock : cpu_lock;
                  ba_q       <= win_dma_d ? dma_addr : cpu_addr;
                  br_w_q     <= win_dma_d ? dma_rw : cpu_rw;
                  ba12_q     <= 1'b1;
                  ba13_q     <= 1'b0;
                  cpu_gnt_q  <= ~win_dma_d;
                  dma_gnt_q  <= win_dma_d;
               end
            end
            S_SETUP: begin
               state_q  <= S_STROBE;
               cnt_q    <= STROBE_LOAD;
               sser_n_q <= 1'b0;
            end
            S_STROBE: begin
               if (cnt_q == 4'd0) begin
                  state_q  <= S_HOLD;
                  cnt_q    <= HOLD_LOAD;
                  sser_n_q <= 1'b1;
                  if (br_w_q) begin
                     if (win_dma_q) dma_rdata_q <= sdrd;
                     else           cpu_rdata_q <= sdrd;
                  end
                  if (HOLD_LOAD == 4'd0) begin
                     cpu_done_q <= ~win_dma_q;
                     dma_done_q <= win_dma_q;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_HOLD: begin
               if (cnt_q == 4'd0) begin
                  state_q    <= S_GAP;
                  owner_q    <= !lock_q ? OWN_NONE : (win_dma_q ? OWN_DMA : OWN_CPU);
                  ba_q       <= '0;
                  ba12_q     <= 1'b0;
                  ba13_q     <= 1'b1;
                  br_w_q     <= 1'b1;
                  cpu_gnt_q  <= 1'b0;
                  dma_gnt_q  <= 1'b0;
                  cpu_done_q <= 1'b0;
                  dma_done_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     cpu_done_q <= ~win_dma_q;
                     dma_done_q <= win_dma_q;
                  end
               end
            end
            S_GAP:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ba        = ba_q;
   assign ba12      = ba12_q;
   assign ba13      = ba13_q;
   assign br_w      = br_w_q;
   assign sser_n    = sser_n_q;
   assign cpu_gnt   = cpu_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_gnt   = dma_gnt_q;
   assign dma_done  = dma_done_q;
   assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/sser_window_ctrl.md
# sser_window_ctrl

Sequencer and arbiter for the serial-port register window (BA13=0, BA12=1). It shares the window between the CPU and the DMA engine and generates the address, direction and SSER strobe timing that the window's state-machine logic needs. It also returns the SDRD read bit. A lock mechanism lets one requester issue an uninterrupted sequence of window accesses, because interleaved accesses would corrupt the window's access-sequence state.

## Interface
- STROBE_CYC, 2, cycles SSER is held low; legal 1..15
- HOLD_CYC, 1, cycles address/direction are held after strobe; legal 1..15
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (level, held until cpu_done)
- cpu_rw  in  1  1=read, 0=write
- cpu_addr  in  4  window offset, driven onto BA7..BA4
- cpu_lock  in  1  keep ownership after this access
- cpu_gnt  out  1  CPU owns the current access
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  1  SDRD value captured for the CPU's last read
- dma_req, dma_rw, dma_addr, dma_lock, dma_gnt, dma_done, dma_rdata: same as the cpu_* ports, for the DMA engine
- ba  out  4  BA7..BA4
- ba12  out  1  window select high bit
- ba13  out  1  window select; 0 while an access is active
- br_w  out  1  bus direction, 1=read
- sser_n  out  1  serial select, active low
- sdrd  in  1  read data bit from the window

## Operation
- Reset and idle values:
  - ba=0, ba12=0, ba13=1, br_w=1, sser_n=1.
  - All gnt, done and rdata outputs = 0.
  - Round-robin pointer favours CPU; lock owner = none.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
- IDLE: arbitrate among active requests.
  - If there is a lock owner, only the owner's request is considered; the other requester waits regardless of pointer.
  - Otherwise: a lone request wins. If both request, the requester not served last wins (CPU first after reset).
  - The winner's addr, rw and lock are latched. The pointer is updated to the winner. Go to SETUP.
- SETUP (1 cycle):
  - gnt of the winner = 1.
  - ba = latched addr, ba12=1, ba13=0, br_w = latched rw, sser_n=1.
- STROBE (STROBE_CYC cycles):
  - sser_n=0; address and direction stay stable.
  - On a read, sdrd is sampled at the clock edge that ends the last STROBE cycle into the winner's rdata.
- HOLD (HOLD_CYC cycles):
  - sser_n=1; address and direction stay stable.
  - The winner's done = 1 in the last HOLD cycle.
  - Lock owner is updated at exit: owner = winner if latched lock=1, else none.
- GAP (1 cycle):
  - Bus returns to idle values; gnt=0.
  - Requests are ignored. The requester must drop req in the cycle after done unless it wants another access.
- Request withdrawn mid-access: the access completes normally and done still pulses. Nothing is re-issued unless req is seen in IDLE.
- rdata is held until the next read by the same requester. Writes leave rdata unchanged.
- Only one gnt may be high in any cycle. Both are 0 outside SETUP, STROBE and HOLD.
- The wait-cycle counter is 4 bits, loaded on state entry.
- Parameters outside 1..15 are a configuration error. Elaboration must fail.

## Timing
- With request seen in IDLE at cycle T and S = STROBE_CYC, H = HOLD_CYC:
  - SETUP and gnt at T+1.
  - sser_n low from T+2 to T+1+S.
  - HOLD from T+2+S to T+1+S+H; done at T+1+S+H.
  - GAP at T+2+S+H; IDLE at T+3+S+H.
- Minimum access-to-access period is S+H+3 cycles.
- With defaults: done at T+4, next arbitration at T+6.
- All outputs are registered, with no combinational path from req to the bus outputs.
- rst_n low forces idle values asynchronously in any state, including mid-STROBE. No done is generated for an aborted access. Lock and pointer are cleared.

## Test plan
- Reset: hold rst_n low with random inputs -> ba13=1, ba12=0, sser_n=1, br_w=1, all gnt/done/rdata = 0.
- CPU read, addr=0x5, sdrd=1, defaults, req seen at T:
  - cpu_gnt at T+1; ba=0x5, ba12=1, ba13=0, br_w=1 from T+1 to T+4.
  - sser_n=0 at T+2 and T+3; cpu_done=1 only at T+4; cpu_rdata=1.
- cpu_req and dma_req both held continuously, lock=0, from reset -> grant order CPU, DMA, CPU, DMA; rdata of each requester changes only on its own read.
- CPU issues three writes with lock = 1, 1, 0 while dma_req is held high -> grant order CPU, CPU, CPU, DMA; dma_gnt stays 0 throughout the CPU sequence.
- rst_n pulsed low during the second STROBE cycle of a DMA read -> sser_n=1 and ba13=1 immediately; no dma_done; after release with both requests high, CPU is granted first.
- STROBE_CYC=4, HOLD_CYC=2; DMA write with dma_req dropped at T+3 -> sser_n low from T+2 to T+5; dma_done at T+7; br_w=0 throughout; no second access.
